// File: rtl/ray_dispatch_reorder.sv
// Raster-order ray job dispatcher: issues (x,y,tag) jobs round-robin to external lanes and
// re-emits their out-of-order RGB results in raster order through a reorder buffer.
module ray_dispatch_reorder #(
    parameter int NUM_LANES = 4,
    parameter int COORD_W   = 13,
    parameter int RGB_W     = 8,
    parameter int ROB_DEPTH = 8,
    localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [COORD_W-1:0]           image_width,
    input  logic [COORD_W-1:0]           image_height,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [NUM_LANES-1:0]         lane_req_valid,
    input  logic [NUM_LANES-1:0]         lane_req_ready,
    output logic [COORD_W-1:0]           lane_req_x,
    output logic [COORD_W-1:0]           lane_req_y,
    output logic [TAG_W-1:0]             lane_req_tag,
    input  logic [NUM_LANES-1:0]         lane_rsp_valid,
    input  logic [NUM_LANES*TAG_W-1:0]   lane_rsp_tag,
    input  logic [NUM_LANES*3*RGB_W-1:0] lane_rsp_rgb,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [3*RGB_W-1:0]           pix_rgb,
    output logic [COORD_W-1:0]           pix_x,
    output logic [COORD_W-1:0]           pix_y,
    output logic                         pix_sof,
    output logic                         pix_eol,
    output logic [1:0]                   fsm_state
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(ROB_DEPTH);

    // Handshakes: a transfer happens in any cycle where valid and ready are both high.
    // lane_req_valid is a function of lane_req_ready; lanes keep ready independent of valid.
    // Responses have no ready: every lane_rsp_valid pulse is consumed in its cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

    state_t                 state, state_next;
    logic [COORD_W-1:0]     width_q, height_q, x_last, y_last;
    logic [COORD_W-1:0]     iss_x, iss_y, out_x, out_y;
    logic [TAG_W-1:0]       wr_ptr, rd_ptr;
    logic [TAG_W:0]         outstanding;
    logic [LANE_W-1:0]      rr_ptr, grant;
    logic                   grant_found;
    int                     idx;
    logic [ROB_DEPTH-1:0]   filled, pending, claimed;
    logic [3*RGB_W-1:0]     slot [ROB_DEPTH];
    logic [TAG_W-1:0]       rsp_tag [NUM_LANES];
    logic [3*RGB_W-1:0]     rsp_rgb [NUM_LANES];
    logic [NUM_LANES-1:0]   rsp_ok;
    logic                   rsp_err;
    logic                   start_ok, start_empty, frame_empty;
    logic                   issue_fire, iss_last, out_last, pix_hs;

    assign x_last      = width_q - COORD_W'(1);
    assign y_last      = height_q - COORD_W'(1);
    assign start_ok    = (state == IDLE) && start;
    assign start_empty = (image_width == '0) || (image_height == '0);
    assign frame_empty = (width_q == '0) || (height_q == '0);
    assign iss_last    = (iss_x == x_last) && (iss_y == y_last);
    assign out_last    = (out_x == x_last) && (out_y == y_last);
    assign issue_fire  = (state == ISSUE) && (outstanding < DEPTH_CNT) && grant_found;
    assign pix_hs      = pix_valid && pix_ready;

    assign busy         = (state != IDLE);
    assign fsm_state    = state;
    assign lane_req_x   = iss_x;
    assign lane_req_y   = iss_y;
    assign lane_req_tag = wr_ptr;
    assign pix_valid    = filled[rd_ptr];
    assign pix_rgb      = slot[rd_ptr];
    assign pix_x        = out_x;
    assign pix_y        = out_y;
    assign pix_sof      = (out_x == '0) && (out_y == '0);
    assign pix_eol      = (out_x == x_last);

    // Round-robin search starting at rr_ptr, wrapping over the lanes.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_LANES;
            if (!grant_found && lane_req_ready[idx]) begin
                grant       = LANE_W'(idx);
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        lane_req_valid = '0;
        if (issue_fire) lane_req_valid[grant] = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            rsp_tag[i] = lane_rsp_tag[i*TAG_W +: TAG_W];
            rsp_rgb[i] = lane_rsp_rgb[i*3*RGB_W +: 3*RGB_W];
        end
    end

    // A response must target an outstanding, still-empty slot; claimed catches two lanes
    // hitting the same slot in one cycle.
    always_comb begin
        rsp_ok  = '0;
        rsp_err = 1'b0;
        claimed = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_rsp_valid[i]) begin
                if (!pending[rsp_tag[i]] || filled[rsp_tag[i]] || claimed[rsp_tag[i]]) begin
                    rsp_err = 1'b1;
                end else begin
                    rsp_ok[i]            = 1'b1;
                    claimed[rsp_tag[i]]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = start_empty ? DRAIN : ISSUE;
            ISSUE:   if (issue_fire && iss_last) state_next = DRAIN;
            DRAIN:   if (frame_empty || (pix_hs && out_last)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            error       <= 1'b0;
            width_q     <= '0;
            height_q    <= '0;
            iss_x       <= '0;
            iss_y       <= '0;
            out_x       <= '0;
            out_y       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            rr_ptr      <= '0;
            filled      <= '0;
            pending     <= '0;
        end else begin
            state <= state_next;
            done  <= (start_ok && start_empty) || ((state == DRAIN) && pix_hs && out_last);
            if (rsp_err) error <= 1'b1;
            if (start_ok) begin
                width_q  <= image_width;
                height_q <= image_height;
                iss_x    <= '0;
                iss_y    <= '0;
                out_x    <= '0;
                out_y    <= '0;
            end
            if (issue_fire) begin
                pending[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + TAG_W'(1);
                rr_ptr          <= (int'(grant) == NUM_LANES - 1) ? '0 : grant + LANE_W'(1);
                if (iss_x == x_last) begin
                    iss_x <= '0;
                    iss_y <= iss_y + COORD_W'(1);
                end else begin
                    iss_x <= iss_x + COORD_W'(1);
                end
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (rsp_ok[i]) filled[rsp_tag[i]] <= 1'b1;
            end
            // Retiring a pixel frees its slot for issue from the next cycle on.
            if (pix_hs) begin
                filled[rd_ptr]  <= 1'b0;
                pending[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + TAG_W'(1);
                if (out_x == x_last) begin
                    out_x <= '0;
                    out_y <= out_y + COORD_W'(1);
                end else begin
                    out_x <= out_x + COORD_W'(1);
                end
            end
            case ({issue_fire, pix_hs})
                2'b10:   outstanding <= outstanding + (TAG_W+1)'(1);
                2'b01:   outstanding <= outstanding - (TAG_W+1)'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (rsp_ok[i]) slot[rsp_tag[i]] <= rsp_rgb[i];
        end
    end
endmodule

// File: tb/tb_ray_dispatch_reorder.sv
// Bench for ray_dispatch_reorder: lane models with per-lane latency, raster-order scoreboard.
module tb_ray_dispatch_reorder;
    localparam int NL = 4;
    localparam int CW = 13;
    localparam int RW = 8;
    localparam int TW = 3;
    localparam int PW = 2*CW + 3*RW + 2;

    logic              clk = 1'b0;
    logic              reset, start, busy, done, error;
    logic [CW-1:0]     image_width, image_height;
    logic [NL-1:0]     lane_req_valid, lane_req_ready;
    logic [CW-1:0]     lane_req_x, lane_req_y;
    logic [TW-1:0]     lane_req_tag;
    logic [NL-1:0]     lane_rsp_valid;
    logic [NL*TW-1:0]  lane_rsp_tag;
    logic [NL*3*RW-1:0] lane_rsp_rgb;
    logic              pix_valid, pix_ready, pix_sof, pix_eol;
    logic [3*RW-1:0]   pix_rgb;
    logic [CW-1:0]     pix_x, pix_y;
    logic [1:0]        fsm_state;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];
    logic [63:0]   lq[NL][$];
    int lat[NL];
    logic hold_rsp;
    int cyc = 0, issue_cnt = 0, pix_cnt = 0, done_cnt = 0, vld_seen = 0;
    int inj_req = 0, inj_ack = 0;
    logic [TW-1:0] inj_tag;
    int exp_rr = 0, tag_cnt = 0;
    logic held_v = 1'b0;
    logic [PW-1:0] held;

    ray_dispatch_reorder dut (
        .clk(clk), .reset(reset), .start(start),
        .image_width(image_width), .image_height(image_height),
        .busy(busy), .done(done), .error(error),
        .lane_req_valid(lane_req_valid), .lane_req_ready(lane_req_ready),
        .lane_req_x(lane_req_x), .lane_req_y(lane_req_y), .lane_req_tag(lane_req_tag),
        .lane_rsp_valid(lane_rsp_valid), .lane_rsp_tag(lane_rsp_tag), .lane_rsp_rgb(lane_rsp_rgb),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
        .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [3*RW-1:0] pattern(input int x, input int y);
        logic [7:0] b;
        b = 8'(x * 3 + y * 5 + 17);
        return {8'(x), 8'(y), b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Lane models: accept offered jobs, answer after lat[i] cycles with a coordinate pattern.
    always @(negedge clk) begin : lane_model
        logic [63:0] e;
        cyc = cyc + 1;
        lane_rsp_valid = '0;
        if (reset) begin
            for (int i = 0; i < NL; i++) lq[i].delete();
            lane_rsp_tag = '0;
            lane_rsp_rgb = '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (lane_req_valid[i] && lane_req_ready[i]) begin
                    lq[i].push_back({32'(cyc + lat[i]), 3'b000, lane_req_tag, lane_req_x, lane_req_y});
                    issue_cnt++;
                end
            end
            for (int i = 0; i < NL; i++) begin
                if (!hold_rsp && lq[i].size() > 0 && int'(lq[i][0][63:32]) <= cyc) begin
                    e = lq[i].pop_front();
                    lane_rsp_valid[i]            = 1'b1;
                    lane_rsp_tag[i*TW +: TW]     = e[28:26];
                    lane_rsp_rgb[i*3*RW +: 3*RW] = pattern(int'(e[25:13]), int'(e[12:0]));
                end
            end
            if (inj_req != inj_ack) begin
                lane_rsp_valid[0]    = 1'b1;
                lane_rsp_tag[0 +: TW] = inj_tag;
                lane_rsp_rgb[0 +: 3*RW] = 24'hdead01;
                inj_ack = inj_req;
            end
        end
    end

    // Monitor: request grant/tag checks, pixel stability and in-order scoreboard pops.
    always @(negedge clk) begin : monitor
        logic [PW-1:0] got, want;
        logic [NL-1:0] want_v;
        int g;
        if (reset) begin
            exp_q.delete();
            exp_rr  = 0;
            tag_cnt = 0;
            held_v  = 1'b0;
        end else begin
            if (done) done_cnt++;
            if ((|lane_req_valid) || pix_valid) vld_seen++;
            if (|lane_req_valid) begin
                g = -1;
                for (int k = 0; k < NL; k++) begin
                    if (g < 0 && lane_req_ready[(exp_rr + k) % NL]) g = (exp_rr + k) % NL;
                end
                want_v = '0;
                if (g >= 0) want_v[g] = 1'b1;
                check("req_grant", lane_req_valid, want_v);
                check("req_tag", lane_req_tag, tag_cnt % 8);
                tag_cnt++;
                exp_rr = (g + 1) % NL;
            end
            got = {pix_x, pix_y, pix_rgb, pix_sof, pix_eol};
            if (held_v) check("pix_hold", {pix_valid, got}, {1'b1, held});
            held_v = pix_valid && !pix_ready;
            held   = got;
            if (pix_valid && pix_ready) begin
                pix_cnt++;
                if (exp_q.size() == 0) begin
                    check("pix_extra", got, '1);
                end else begin
                    want = exp_q.pop_front();
                    check("pix", got, want);
                end
            end
        end
    end

    task automatic push_frame(input int w, input int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                exp_q.push_back({13'(x), 13'(y), pattern(x, y), (x == 0 && y == 0), (x == w - 1)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0 plain, 1 pix_ready stall, 2 withheld responses, 3 start while busy
    task automatic run_frame(input int w, input int h, input int mode, input logic err_exp);
        int base_i, base_p, base_d, k, m;
        logic stalled;
        push_frame(w, h);
        base_i = issue_cnt;
        base_p = pix_cnt;
        base_d = done_cnt;
        stalled = 1'b0;
        hold_rsp = (mode == 2);
        tick();
        start = 1'b1; image_width = CW'(w); image_height = CW'(h);
        tick();
        start = 1'b0;
        k = 0;
        while (done_cnt == base_d && k < 600) begin
            if (mode == 1 && !stalled && pix_cnt - base_p >= 10) begin
                pix_ready = 1'b0;
                repeat (20) tick();
                pix_ready = 1'b1;
                stalled = 1'b1;
            end
            if (mode == 2 && k == 20) begin
                check("hold_issued", issue_cnt - base_i, 8);
                check("hold_no_valid", lane_req_valid, 0);
                hold_rsp = 1'b0;
                m = 0;
                while (issue_cnt - base_i == 8 && m < 6) begin
                    tick();
                    m++;
                end
                check("hold_resume", issue_cnt - base_i > 8, 1);
            end
            if (mode == 3) start = (k == 4);
            tick();
            k++;
        end
        start = 1'b0;
        repeat (3) tick();
        check("frame_done", done_cnt - base_d, 1);
        check("frame_issues", issue_cnt - base_i, w * h);
        check("frame_pixels", pix_cnt - base_p, w * h);
        check("frame_exp_left", exp_q.size(), 0);
        check("frame_busy", busy, 0);
        check("frame_error", error, err_exp);
    endtask

    initial begin
        int base_i, base_d, base_v, k;
        reset = 1'b1; start = 1'b0; image_width = '0; image_height = '0;
        lane_req_ready = '1; pix_ready = 1'b1; hold_rsp = 1'b0; inj_tag = '0;
        lat = '{3, 3, 3, 3};
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_req_valid", lane_req_valid, 0);
        reset = 1'b0;
        tick();

        run_frame(4, 2, 3, 1'b0);
        lat = '{1, 7, 2, 5};
        run_frame(8, 4, 0, 1'b0);
        lat = '{3, 3, 3, 3};
        run_frame(8, 4, 2, 1'b0);
        lat = '{2, 4, 1, 3};
        run_frame(8, 4, 1, 1'b0);

        base_d = done_cnt;
        base_v = vld_seen;
        start = 1'b1; image_width = '0; image_height = CW'(5);
        tick();
        start = 1'b0;
        check("zero_done", done, 1);
        tick();
        check("zero_done_pulse", done, 0);
        check("zero_busy", busy, 0);
        repeat (5) tick();
        check("zero_no_valid", vld_seen - base_v, 0);
        check("zero_done_count", done_cnt - base_d, 1);

        lat = '{3, 3, 3, 3};
        push_frame(8, 4);
        base_i = issue_cnt;
        start = 1'b1; image_width = CW'(8); image_height = CW'(4);
        tick();
        start = 1'b0;
        k = 0;
        while (issue_cnt - base_i < 5 && k < 50) begin
            tick();
            k++;
        end
        check("abort_wait", issue_cnt - base_i >= 5, 1);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_pix_valid", pix_valid, 0);
        check("abort_req_valid", lane_req_valid, 0);
        tick();

        run_frame(2, 2, 0, 1'b0);
        inj_tag = 3'd0;
        inj_req++;
        repeat (2) tick();
        check("stray_error", error, 1);
        lane_req_ready = 4'b0101;
        run_frame(4, 2, 0, 1'b1);
        lane_req_ready = '1;
        repeat (10) tick();
        check("error_sticky", error, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
